// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_pkg : shared types, sizes and helpers for the rr_arbiter4 slice |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick : combinational winner select, round-robin or fixed prio    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_mode,
  output logic [ID_W-1:0]  o_win_id,
  output logic             o_win_valid
);

  logic [ID_W-1:0]  w_ptr;
  logic [ID_W-1:0]  w_idx;
  logic [N_REQ-1:0] w_rot;

  // Rotate so the search origin sits at bit 0; fixed priority uses origin 0
  // and scans for the highest index instead of the lowest.
  always_comb begin
    w_ptr = i_mode ? i_ptr : '0;
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = i_req[ID_W'(i) + w_ptr];
    end
    w_idx = '0;
    if (i_mode) begin
      for (int i = N_REQ-1; i >= 0; i--) begin
        if (w_rot[i]) w_idx = ID_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_rot[i]) w_idx = ID_W'(i);
      end
    end
  end

  assign o_win_id    = w_idx + w_ptr;
  assign o_win_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter4 : 4-client arbiter, RR/fixed priority, hold timeout     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic [ID_W-1:0]  w_win_id;
  logic             w_win_valid;
  logic             w_hold_req;
  logic             w_hold_max;

  rr_pick u_pick (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .i_mode      (mode),
    .o_win_id    (w_win_id),
    .o_win_valid (w_win_valid)
  );

  assign w_hold_req = req[r_gnt_id];
  assign w_hold_max = (r_hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_state     <= GRANT;
            r_gnt       <= onehot(w_win_id);
            r_gnt_id    <= w_win_id;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= CNT_W'(1);
          end
        end
        GRANT: begin
          // Any release, voluntary or forced, lands in IDLE for one bubble.
          if (!w_hold_req || w_hold_max) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_ptr       <= r_gnt_id + ID_W'(1);
            r_timeout   <= w_hold_req;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rr_arbiter4 : vector table + scoreboard bench for rr_arbiter4    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_rr_arbiter4;

  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
    logic       to;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int   n_chk;
  int   n_pass;
  int   n_step;
  bit   done;
  vec_t tbl[$];
  vec_t sb[$];

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input string name, input logic [3:0] eg,
                           input logic [1:0] eid, input logic ev, input logic eto);
    n_chk++;
    if (gnt === eg && gnt_id === eid && gnt_valid === ev && timeout === eto) n_pass++;
    else $display("FAIL %s: got gnt=%b id=%0d v=%b to=%b, expected gnt=%b id=%0d v=%b to=%b",
                  name, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, eto);
  endtask

  // Drive one cycle of stimulus; the expectation rides the scoreboard until the edge.
  task automatic step(input string name, input logic [3:0] r, input logic m,
                      input logic [3:0] eg, input logic [1:0] eid, input logic ev,
                      input logic eto);
    vec_t e;
    req  = r;
    mode = m;
    e = '{req: r, mode: m, gnt: eg, id: eid, v: ev, to: eto};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_step++;
    check_now($sformatf("%s#%0d", name, n_step), e.gnt, e.id, e.v, e.to);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic m, input logic [3:0] g,
                              input logic [1:0] i, input logic v, input logic t);
    mk = '{req: r, mode: m, gnt: g, id: i, v: v, to: t};
  endfunction

  always @(negedge clk) begin
    if (!done) begin
      n_chk++;
      if ($onehot0(gnt) && (gnt_valid === |gnt) && (!gnt_valid || gnt === (4'b0001 << gnt_id)))
        n_pass++;
      else $display("FAIL invariant @%0t: gnt=%b id=%0d v=%b", $time, gnt, gnt_id, gnt_valid);
    end
  end

  initial begin
    done = 1'b0;
    n_chk = 0;
    n_pass = 0;
    n_step = 0;
    rst = 1'b1;
    req = '0;
    mode = 1'b0;

    // Fixed priority, then a voluntary release of client 3.
    tbl.push_back(mk(4'b1011, 0, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b1011, 0, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b0011, 0, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(4'b0011, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b0011, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 4'b0000, 2'd1, 0, 0));
    // Round-robin fairness after reset (ptr = 0).
    tbl.push_back(mk(4'b1111, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b1110, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1101, 1, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(4'b1011, 1, 4'b0000, 2'd2, 0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b0111, 1, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 2'd0, 0, 0));
    // Mode change during a grant only matters at the next arbitration (ptr = 1).
    tbl.push_back(mk(4'b0010, 1, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1011, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(4'b1001, 0, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(4'b1001, 0, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(4'b0001, 1, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(4'b1001, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 2'd0, 0, 0));

    @(posedge clk);
    #1;
    check_now("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Asynchronous reset while client 2 holds the grant.
    step("rst_mid", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    check_now("rst_async_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_regrant", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    step("rst_release", 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

    for (int k = 0; k < 7; k++)
      step("fixed", tbl[k].req, tbl[k].mode, tbl[k].gnt, tbl[k].id, tbl[k].v, tbl[k].to);
    apply_reset();
    for (int k = 7; k < tbl.size(); k++)
      step("rr_mode", tbl[k].req, tbl[k].mode, tbl[k].gnt, tbl[k].id, tbl[k].v, tbl[k].to);

    // Forced release with a competing requester.
    apply_reset();
    for (int k = 0; k < 8; k++) step("to_hold", 4'b0011, 1, 4'b0001, 2'd0, 1, 0);
    step("to_pulse", 4'b0011, 1, 4'b0000, 2'd0, 0, 1);
    step("to_next", 4'b0011, 1, 4'b0010, 2'd1, 1, 0);
    step("to_drop", 4'b0000, 1, 4'b0000, 2'd1, 0, 0);
    step("to_idle", 4'b0000, 1, 4'b0000, 2'd1, 0, 0);

    // Sole requester: 8-cycle grant, one timeout bubble, period 9.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) step("sole_hold", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("sole_bubble", 4'b0100, 0, 4'b0000, 2'd2, 0, 1);
    end
    step("sole_idle", 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
Four-requester arbiter that shares one downstream resource, such as a bus port or encoder datapath, between four clients.
- Each client raises a request and holds it while it owns the resource.
- The arbiter issues a registered one-hot grant plus an encoded grant ID.
- Mode selects round-robin or fixed priority.
- A hold-timeout counter stops any single client from starving the others.

Parameters:
N_REQ, 4, number of requesters; fixed at 4 in this revision
MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 2..255
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
req  input  4  request per client; bit 3 = client 3
mode  input  1  0 = fixed priority (3 > 2 > 1 > 0), 1 = round-robin
gnt  output  4  one-hot grant, registered; all zero when idle
gnt_id  output  2  binary index of the granted client; holds last value when idle
gnt_valid  output  1  high whenever gnt is non-zero
timeout  output  1  one-cycle pulse on the cycle a grant is forcibly revoked

Behaviour:
- Reset: one clock domain; rst is asynchronous, active-high. While rst is high:
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0;
  - ptr = 0, hold_cnt = 0, state = IDLE.
  - Reset asserted mid-grant drops gnt immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - If req == 0, stay in IDLE; outputs stay at zero, except gnt_id holds its last value.
  - Else pick a winner W and, on the next edge, go to GRANT with gnt = 1<<W, gnt_id = W, gnt_valid = 1, hold_cnt = 1.
  - Latency: req sampled at edge N gives gnt visible after edge N, so 1 cycle.
- Winner selection:
  - mode = 0: highest set index wins.
  - mode = 1: search starts at ptr and goes upward modulo 4; first set bit wins.
  - mode is sampled only in IDLE. A change of mode during GRANT has no effect until the next arbitration.
- GRANT, holder H:
  - If req[H] = 0: go to IDLE next edge, clear gnt and gnt_valid, set ptr = (H+1) mod 4.
  - Else if hold_cnt == MAX_HOLD: forced release.
    - Go to IDLE; clear gnt; pulse timeout = 1 for exactly one cycle (the first IDLE cycle).
    - Set ptr = (H+1) mod 4.
  - Else: keep the grant and increment hold_cnt.
  - Requests from non-holders are ignored during GRANT.
- Bubble: every release, voluntary or forced, is followed by exactly one IDLE cycle with gnt = 0 before any new grant. So a hold of MAX_HOLD cycles is followed by at least one idle cycle.
- Sole requester after timeout:
  - After the bubble it is re-granted. The rotated ptr makes no difference when no other client is requesting.
  - In mode 0, a timeout does not change priority; client 3 re-wins if still requesting.
- ptr:
  - Updates only on release.
  - Also updates in mode 0, so switching to mode 1 starts fairly.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid equals |gnt.
  - gnt_id equals the index of the set bit whenever gnt_valid = 1.
- req glitches in IDLE are treated as real requests. No synchronisation is done here; req is assumed to be in the clk domain.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam N_REQ = 4, ID_W = 2;
  - function onehot(id) returning 4 bits.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[3:0], ptr[1:0], mode.
  - Outputs: win_id[1:0], win_valid.
  - Implementation: rotate req right by ptr, apply a fixed priority encoder, rotate the index back. Mode 0 forces ptr to 0 and uses high-index-first ordering.
- Top level holds only the FSM, ptr, hold_cnt and output registers.

Test Plan:
1. Reset mid-grant: grant client 2, assert rst asynchronously between edges -> gnt = 0, gnt_valid = 0 immediately; after release, req = 4'b0100 -> gnt = 4'b0100 one cycle later, gnt_id = 2.
2. Fixed priority, mode = 0: req = 4'b1011 -> gnt = 4'b1000, gnt_id = 3; drop req[3] -> 1 bubble cycle, then gnt = 4'b0010, gnt_id = 1.
3. Round-robin fairness, mode = 1, req = 4'b1111 held, each client releasing after 2 cycles -> grant order 0, 1, 2, 3, 0, with exactly one gnt = 0 cycle between grants.
4. Timeout, MAX_HOLD = 8, mode = 1: req = 4'b0011 held constantly -> client 0 held for 8 cycles, timeout = 1 for one cycle with gnt = 0, next grant = client 1 (gnt_id = 1).
5. Sole requester timeout: req = 4'b0100 held forever -> 8-cycle grant, 1 bubble with timeout pulse, re-grant to 2, repeating with period 9.
6. Mode change during grant: grant client 1 in mode 1, switch mode to 0 while req = 4'b1001 pending, release 1 -> next grant = client 3.
7. Invariant check: every cycle of scenarios 1-6, gnt is zero or one-hot, gnt_valid == |gnt, and gnt_id matches gnt when valid.
